// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus bundle: instruction-memory req/ack, IF/ID valid/ready and redirect inputs.
// master = fetch sequencer side; slave = memory / decode / redirect-source side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, fetches over imem req/ack, hands {instr, pc} to IF/ID.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_squashed event counters.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       PC_INC       = 1
) (
  input  logic        clock,
  input  logic        reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_squashed,
`endif
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FLUSH = 2'd2, HOLD = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic [ADDR_W-1:0] id_pc_q, id_pc_nxt;
  logic [DATA_W-1:0] id_instr_q, id_instr_nxt;
  logic              imem_req_q, id_valid_q;

  logic              ack, redir;
  logic [ADDR_W-1:0] target;

  assign ack    = bus.imem_ack;
  assign redir  = bus.redirect_valid;
  assign target = bus.redirect_target;

  // State and datapath registers; imem_req/id_valid are registered decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      req_addr   <= '0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      imem_req_q <= 1'b0;
      id_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      id_pc_q    <= id_pc_nxt;
      id_instr_q <= id_instr_nxt;
      imem_req_q <= (state_nxt == REQ) || (state_nxt == FLUSH);
      id_valid_q <= (state_nxt == HOLD);
    end
  end

  // Next-state: redirect beats ack, ack beats id_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        if (redir)    state_nxt = ack ? REQ : FLUSH;
        else if (ack) state_nxt = HOLD;
      end
      FLUSH: if (ack) state_nxt = REQ;
      HOLD:  if (redir || bus.id_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath updates; a wrong-path request keeps its address until the memory acks it.
  always_comb begin
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    id_pc_nxt    = id_pc_q;
    id_instr_nxt = id_instr_q;
    case (state)
      IDLE: begin
        if (redir) begin
          pc_nxt       = target;
          req_addr_nxt = target;
        end else begin
          req_addr_nxt = pc;
        end
      end
      REQ: begin
        if (redir) begin
          pc_nxt = target;
          if (ack) req_addr_nxt = target;
        end else if (ack) begin
          id_instr_nxt = bus.imem_rdata;
          id_pc_nxt    = req_addr;
          pc_nxt       = req_addr + ADDR_W'(PC_INC);
        end
      end
      FLUSH: begin
        if (redir) pc_nxt = target;
        if (ack)   req_addr_nxt = redir ? target : pc;
      end
      HOLD: begin
        if (redir) begin
          pc_nxt       = target;
          req_addr_nxt = target;
        end else if (bus.id_ready) begin
          req_addr_nxt = pc;
        end
      end
      default: ;
    endcase
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = req_addr;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic fetched_evt, squashed_evt;

  assign fetched_evt  = id_valid_q & bus.id_ready & ~redir;
  assign squashed_evt = ((state == REQ) & ack & redir) | ((state == FLUSH) & ack) |
                        ((state == HOLD) & redir);

  // Free-running wrapping event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched  <= 16'd0;
      perf_squashed <= 16'd0;
    end else begin
      if (fetched_evt)  perf_fetched  <= perf_fetched + 16'd1;
      if (squashed_evt) perf_squashed <= perf_squashed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run
// checked against a stream-level model of the delivered instruction sequence.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        id_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        mem_manual, man_ack, auto_ack;
  int          lat;
  bit          rand_lat;
  int          checks, errors;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_squashed;
`endif

  fetch_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  fetch_sequencer dut (
    .clock(clock),
    .reset(reset),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched),
    .perf_squashed(perf_squashed),
`endif
    .bus(bus.master)
  );

  assign bus.imem_ack        = mem_manual ? man_ack : auto_ack;
  assign bus.imem_rdata      = bus.imem_addr ^ 16'hA5A5;
  assign bus.id_ready        = id_ready;
  assign bus.redirect_valid  = redirect_valid;
  assign bus.redirect_target = redirect_target;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: each request is acked after cur_lat wait cycles (0 = same cycle as req).
  int wcnt, cur_lat;
  bit in_req;
  initial begin
    auto_ack = 1'b0; in_req = 1'b0; wcnt = 0; cur_lat = 0;
  end
  always @(posedge clock) begin
    #1;
    if (reset || !bus.imem_req) begin
      in_req   = 1'b0;
      auto_ack = 1'b0;
    end else begin
      if (!in_req || auto_ack) begin
        in_req  = 1'b1;
        wcnt    = 0;
        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
      end else begin
        wcnt++;
      end
      auto_ack = (wcnt >= cur_lat);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
    mem_manual = 1'b0; man_ack = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
    mem_manual = 1'b0; man_ack = 1'b0; lat = 0; rand_lat = 0;
    step(); step();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc} !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h, expected all zero",
               bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_fetch: req=%b addr=%h valid=%b, expected req=1 addr=0000 valid=0",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
  endtask

  task automatic test_zero_wait();
    logic [15:0] e;
    lat = 0; do_reset(); id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      e = 16'(i / 2);
      checks++;
      if (bus.id_valid !== 1'(i % 2)) begin
        errors++;
        $display("FAIL zero_wait_valid[%0d]: id_valid=%b, expected %b", i, bus.id_valid, 1'(i % 2));
      end
      if (i % 2 == 1) begin
        checks++;
        if ({bus.id_pc, bus.id_instr} !== {e, e ^ 16'hA5A5}) begin
          errors++;
          $display("FAIL zero_wait_data[%0d]: pc=%h instr=%h, expected pc=%h instr=%h",
                   i, bus.id_pc, bus.id_instr, e, e ^ 16'hA5A5);
        end
      end
    end
  endtask

  task automatic test_ack_latency();
    logic [15:0] k16;
    lat = 2; do_reset(); id_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      k16 = 16'(k);
      for (int j = 0; j < 3; j++) begin
        step();
        checks++;
        if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, k16, 1'b0}) begin
          errors++;
          $display("FAIL latency_wait[%0d.%0d]: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                   k, j, bus.imem_req, bus.imem_addr, bus.id_valid, k16);
        end
      end
      step();
      checks++;
      if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, k16, k16 ^ 16'hA5A5}) begin
        errors++;
        $display("FAIL latency_deliver[%0d]: valid=%b pc=%h instr=%h, expected valid=1 pc=%h",
                 k, bus.id_valid, bus.id_pc, bus.id_instr, k16);
      end
    end
    lat = 0;
  endtask

  task automatic test_hold_stall();
    lat = 0; do_reset(); id_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    id_ready = 1'b0;
    checks++;
    if ({bus.id_valid, bus.id_pc} !== {1'b1, 16'h0002}) begin
      errors++;
      $display("FAIL stall_entry: valid=%b pc=%h, expected valid=1 pc=0002", bus.id_valid, bus.id_pc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_req} !==
          {1'b1, 16'h0002, 16'h0002 ^ 16'hA5A5, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b, expected 1/0002/a5a7/0",
                 i, bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_req);
      end
    end
    id_ready = 1'b1;
    step();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 16'h0003, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b, expected req=1 addr=0003 valid=0",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
  endtask

  task automatic test_redirect_pending();
    lat = 0; do_reset(); id_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    lat = 2;
    step();
    redirect_valid = 1'b1; redirect_target = 16'h0040;
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.imem_ack} !== {1'b1, 16'h0005, 1'b0}) begin
      errors++;
      $display("FAIL redir_pending_start: req=%b addr=%h ack=%b, expected 1/0005/0",
               bus.imem_req, bus.imem_addr, bus.imem_ack);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      redirect_valid = 1'b0;
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 16'h0005, 1'b0}) begin
        errors++;
        $display("FAIL redir_flush_addr[%0d]: req=%b addr=%h valid=%b, expected 1/0005/0",
                 i, bus.imem_req, bus.imem_addr, bus.id_valid);
      end
    end
    lat = 0;
    step();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 16'h0040, 1'b0}) begin
      errors++;
      $display("FAIL redir_refetch: req=%b addr=%h valid=%b, expected 1/0040/0",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
    step();
    checks++;
    if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 16'h0040, 16'h0040 ^ 16'hA5A5}) begin
      errors++;
      $display("FAIL redir_first_pc: valid=%b pc=%h instr=%h, expected valid=1 pc=0040 instr=a5e5",
               bus.id_valid, bus.id_pc, bus.id_instr);
    end
  endtask

  task automatic test_redirect_hold_and_wrap();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'h1000; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    lat = 0; do_reset(); id_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_target = 16'h1000;
    for (int n = 0; n < 4; n++) begin
      step();
      redirect_valid = 1'b0;
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, exp_pc[n], 1'b0}) begin
        errors++;
        $display("FAIL hold_redir_fetch[%0d]: req=%b addr=%h valid=%b, expected 1/%h/0",
                 n, bus.imem_req, bus.imem_addr, bus.id_valid, exp_pc[n]);
      end
      step();
      checks++;
      if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, exp_pc[n], exp_pc[n] ^ 16'hA5A5}) begin
        errors++;
        $display("FAIL hold_redir_deliver[%0d]: valid=%b pc=%h instr=%h, expected pc=%h",
                 n, bus.id_valid, bus.id_pc, bus.id_instr, exp_pc[n]);
      end
      if (n == 0) begin
        redirect_valid = 1'b1; redirect_target = 16'hFFFF;
      end
    end
  endtask

  task automatic test_reset_flush();
    lat = 0; do_reset(); id_ready = 1'b1;
    step(); step();
    lat = 3;
    step();
    redirect_valid = 1'b1; redirect_target = 16'h0200;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL flush_pending: req=%b addr=%h, expected req=1 addr=0001", bus.imem_req, bus.imem_addr);
    end
    mem_manual = 1'b1; man_ack = 1'b1; reset = 1'b1;
    step();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc} !== 50'd0) begin
      errors++;
      $display("FAIL flush_reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h, expected all zero",
               bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc);
    end
    reset = 1'b0;
    step();
    man_ack = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL flush_restart: req=%b addr=%h valid=%b, expected 1/0000/0",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
    step();
    man_ack = 1'b1;
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL flush_stray_ack: req=%b addr=%h valid=%b, expected still waiting on 0000",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
    step();
    man_ack = 1'b0; mem_manual = 1'b0; lat = 0;
    checks++;
    if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 16'h0000, 16'hA5A5}) begin
      errors++;
      $display("FAIL flush_first_deliver: valid=%b pc=%h instr=%h, expected 1/0000/a5a5",
               bus.id_valid, bus.id_pc, bus.id_instr);
    end
  endtask

  // Stream model: delivered PCs run consecutively, restarting at each redirect target.
  task automatic test_random();
    logic [15:0] exp_next, prev_addr, prev_pc;
    bit          prev_pending, prev_hold;
    int          hs;
    hs = 0; prev_pending = 0; prev_hold = 0; prev_addr = 16'h0; prev_pc = 16'h0;
    rand_lat = 1; do_reset();
    exp_next = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      step();
      id_ready        = ($urandom_range(0, 9) < 7);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = 16'($urandom);
      if (prev_pending) begin
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, prev_addr}) begin
          errors++;
          $display("FAIL rand_addr_stable[%0d]: req=%b addr=%h, expected req=1 addr=%h",
                   i, bus.imem_req, bus.imem_addr, prev_addr);
        end
      end
      if (prev_hold) begin
        checks++;
        if ({bus.id_valid, bus.id_pc} !== {1'b1, prev_pc}) begin
          errors++;
          $display("FAIL rand_hold_stable[%0d]: valid=%b pc=%h, expected valid=1 pc=%h",
                   i, bus.id_valid, bus.id_pc, prev_pc);
        end
      end
      if (bus.id_valid && id_ready && !redirect_valid) begin
        hs++;
        checks++;
        if ({bus.id_pc, bus.id_instr} !== {exp_next, exp_next ^ 16'hA5A5}) begin
          errors++;
          $display("FAIL rand_deliver[%0d]: pc=%h instr=%h, expected pc=%h instr=%h",
                   i, bus.id_pc, bus.id_instr, exp_next, exp_next ^ 16'hA5A5);
        end
        exp_next = exp_next + 16'd1;
      end
      if (redirect_valid) exp_next = redirect_target;
      prev_pending = bus.imem_req && !bus.imem_ack;
      prev_addr    = bus.imem_addr;
      prev_hold    = bus.id_valid && !id_ready && !redirect_valid;
      prev_pc      = bus.id_pc;
    end
    redirect_valid = 1'b0; rand_lat = 0;
    checks++;
    if (hs < 40) begin
      errors++;
      $display("FAIL rand_progress: %0d handshakes, expected at least 40", hs);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
    mem_manual = 1'b0; man_ack = 1'b0; lat = 0; rand_lat = 0;
    test_reset();
    test_zero_wait();
    test_ack_latency();
    test_hold_stall();
    test_redirect_pending();
    test_redirect_hold_and_wrap();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
